lbp_stream_engine: RTL and testbench

//   Streaming 3x3 Local Binary Pattern engine. Replaces the 9-reads-per-pixel LBP

---
 rtl/lbp_stream_engine.sv | 139 +++++++++++++
 tb/tb_lbp_stream_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lbp_stream_engine.sv
// rtl/lbp_stream_engine.sv - streaming 3x3 LBP engine: one gray read and one LBP write per cycle.
// Define LBP_RIU2_EN to emit rotation-invariant uniform codes (0..9) instead of raw 8-bit codes.
module lbp_stream_engine #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gray_ready,
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   input  logic [PIX_W-1:0]  gray_data,
   output logic              lbp_valid,
   output logic [ADDR_W-1:0] lbp_addr,
   output logic [7:0]        lbp_data,
   output logic              finish
);

   localparam int N  = IMG_W * IMG_H;
   localparam int CW = $clog2(N + IMG_W + 3);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [CW-1:0]     C_LAST_RD = CW'(N - 1);
   localparam logic [CW-1:0]     C_GEN_LO  = CW'(IMG_W + 2);
   localparam logic [CW-1:0]     C_GEN_HI  = CW'(N + IMG_W + 1);
   localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(N - 1);
   localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
   localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

   state_t              r_state, w_next;
   logic [CW-1:0]       r_cyc;
   logic                r_vld_d;
   logic [ADDR_W-1:0]   r_k;
   logic [XW-1:0]       r_col;
   logic [YW-1:0]       r_row;
   logic                r_lbp_valid;
   logic [ADDR_W-1:0]   r_lbp_addr;
   logic [7:0]          r_lbp_data;
   logic                r_finish;
   logic [PIX_W-1:0]    r_sr [2*IMG_W+2];

   logic                w_run, w_gen, w_last_wr, w_border;
   logic [7:0]          w_raw, w_code;
   logic [PIX_W-1:0]    w_c;

   assign w_run     = (r_state == S_READ) || (r_state == S_FLUSH);
   // Cycle c of a frame produces output k = c-(IMG_W+2), with pixel j = c-1 on gray_data.
   assign w_gen     = w_run && (r_cyc >= C_GEN_LO) && (r_cyc <= C_GEN_HI);
   assign w_last_wr = r_lbp_valid && (r_lbp_addr == A_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (gray_ready)         w_next = S_READ;
         S_READ:  if (r_cyc == C_LAST_RD) w_next = S_FLUSH;
         S_FLUSH: if (w_last_wr)          w_next = S_DONE;
         default: w_next = S_DONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cyc       <= '0;
         r_vld_d     <= 1'b0;
         r_k         <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_lbp_valid <= 1'b0;
         r_lbp_addr  <= '0;
         r_lbp_data  <= '0;
         r_finish    <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_vld_d     <= gray_req;
         r_cyc       <= w_run ? r_cyc + 1'b1 : '0;
         r_lbp_valid <= w_gen;
         if (r_state == S_IDLE) begin
            r_k   <= '0;
            r_col <= '0;
            r_row <= '0;
         end else if (w_gen) begin
            r_lbp_addr <= r_k;
            r_lbp_data <= w_code;
            if (r_k != A_LAST) r_k <= r_k + 1'b1;
            if (r_col == X_LAST) begin
               r_col <= '0;
               if (r_row != Y_LAST) r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if ((r_state == S_FLUSH) && w_last_wr) r_finish <= 1'b1;
      end
   end

   // r_sr[i] holds pixel j-1-i; contents are don't-care until the window fills.
   always_ff @(posedge clk) begin
      if (r_vld_d) begin
         r_sr[0] <= gray_data;
         for (int i = 1; i < 2*IMG_W+2; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign w_c = r_sr[IMG_W];
   assign w_raw = {gray_data         >= w_c,
                   r_sr[0]           >= w_c,
                   r_sr[1]           >= w_c,
                   r_sr[IMG_W-1]     >= w_c,
                   r_sr[IMG_W+1]     >= w_c,
                   r_sr[2*IMG_W-1]   >= w_c,
                   r_sr[2*IMG_W]     >= w_c,
                   r_sr[2*IMG_W+1]   >= w_c};

   assign w_border = (r_row == '0) || (r_row == Y_LAST) || (r_col == '0) || (r_col == X_LAST);

`ifdef LBP_RIU2_EN
   logic [7:0] w_seq, w_trans;
   // Circular order TL,T,TR,R,BR,B,BL,L from bit 0 upward.
   assign w_seq   = {w_raw[3], w_raw[5], w_raw[6], w_raw[7], w_raw[4], w_raw[2], w_raw[1], w_raw[0]};
   assign w_trans = w_seq ^ {w_seq[0], w_seq[7:1]};
   assign w_code  = w_border ? 8'd0 :
                    ($countones(w_trans) <= 2) ? 8'($countones(w_raw)) : 8'd9;
`else
   assign w_code  = w_border ? 8'd0 : w_raw;
`endif

   assign gray_req  = (r_state == S_READ);
   assign gray_addr = gray_req ? ADDR_W'(r_cyc) : '0;
   assign lbp_valid = r_lbp_valid;
   assign lbp_addr  = r_lbp_addr;
   assign lbp_data  = r_lbp_data;
   assign finish    = r_finish;

endmodule

// File: tb/tb_lbp_stream_engine.sv
// tb/tb_lbp_stream_engine.sv - table-driven bench for lbp_stream_engine on a 4x4 image.
module tb_lbp_stream_engine;
   localparam int W = 4, H = 4, N = 16, AW = 4;

   logic          clk = 1'b0;
   logic          reset, gray_ready;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [7:0]    gray_data;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic [7:0]    lbp_data;
   logic          finish;

   always #5 clk = ~clk;

   lbp_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .gray_ready(gray_ready),
      .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
      .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
      .finish(finish));

   logic [7:0] mem [N];
   always @(posedge clk) gray_data <= mem[gray_addr];

   typedef struct { int img; int addr; logic [7:0] raw; } vec_t;
   vec_t tbl [$];

   int errors = 0, checks = 0;
   logic [7:0] got [N];
   int req_cnt, rd_bad, wr_cnt, addr_bad, first_wr, last_wr, fin_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [7:0] map_code(input logic [7:0] raw);
`ifdef LBP_RIU2_EN
      int ord [8] = '{0, 1, 2, 4, 7, 6, 5, 3};
      int u = 0, p = 0;
      for (int i = 0; i < 8; i++) begin
         if (raw[ord[i]] != raw[ord[(i+1)%8]]) u++;
         if (raw[i]) p++;
      end
      return (u <= 2) ? 8'(p) : 8'd9;
`else
      return raw;
`endif
   endfunction

   function automatic logic [7:0] model(input int k);
      int r = k / W, c = k % W;
      logic [7:0] ctr, code;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'd0;
      ctr = mem[k];
      code[0] = mem[k-W-1] >= ctr;  code[1] = mem[k-W] >= ctr;  code[2] = mem[k-W+1] >= ctr;
      code[3] = mem[k-1]   >= ctr;  code[4] = mem[k+1]   >= ctr;
      code[5] = mem[k+W-1] >= ctr;  code[6] = mem[k+W] >= ctr;  code[7] = mem[k+W+1] >= ctr;
      return map_code(code);
   endfunction

   task automatic load_img(input int id);
      for (int i = 0; i < N; i++)
         case (id)
            0:       mem[i] = 8'h55;
            1:       mem[i] = 8'(i);
            2:       mem[i] = (i == 5) ? 8'd200 : 8'd10;
            default: mem[i] = 8'($urandom_range(0, 255));
         endcase
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      gray_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_frame(input bit hold_ready);
      int cyc = 0;
      int exp_addr = 0;
      req_cnt = 0; rd_bad = 0; wr_cnt = 0; addr_bad = 0;
      first_wr = -1; last_wr = -1; fin_cyc = -1;
      for (int i = 0; i < N; i++) got[i] = 8'hxx;
      @(negedge clk) gray_ready = 1'b1;
      @(negedge clk);
      if (!hold_ready) gray_ready = 1'b0;
      while (fin_cyc < 0 && cyc < 200) begin
         if (gray_req) begin
            if (gray_addr !== AW'(req_cnt)) rd_bad++;
            req_cnt++;
         end
         if (lbp_valid) begin
            if (lbp_addr !== AW'(exp_addr)) addr_bad++;
            if (!$isunknown(lbp_addr)) got[lbp_addr] = lbp_data;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
            exp_addr++;
         end
         if (finish) fin_cyc = cyc;
         @(negedge clk);
         cyc++;
      end
      gray_ready = 1'b0;
      check("req_cycles", req_cnt, N);
      check("read_addr_order", rd_bad, 0);
      check("write_count", wr_cnt, N);
      check("write_addr_order", addr_bad, 0);
      check("first_write_cycle", first_wr, W + 3);
      check("finish_lag", fin_cyc - last_wr, 1);
      repeat (3) @(negedge clk);
      check("finish_sticky", finish, 1);
      check("done_no_write", lbp_valid, 0);
      check("done_no_read", gray_req, 0);
   endtask

   task automatic check_table(input int img);
      foreach (tbl[i])
         if (tbl[i].img == img)
            check($sformatf("img%0d_addr%0d", img, tbl[i].addr), got[tbl[i].addr], map_code(tbl[i].raw));
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_gray_req"},  gray_req,  0);
      check({tag, "_gray_addr"}, gray_addr, 0);
      check({tag, "_lbp_valid"}, lbp_valid, 0);
      check({tag, "_lbp_addr"},  lbp_addr,  0);
      check({tag, "_lbp_data"},  lbp_data,  0);
      check({tag, "_finish"},    finish,    0);
   endtask

   initial begin
      for (int a = 0; a < N; a++)
         tbl.push_back('{0, a, (a == 5 || a == 6 || a == 9 || a == 10) ? 8'hFF : 8'h00});
      tbl.push_back('{1, 5, 8'hF0});  tbl.push_back('{1, 6, 8'hF0});
      tbl.push_back('{1, 9, 8'hF0});  tbl.push_back('{1, 10, 8'hF0});
      tbl.push_back('{1, 0, 8'h00});  tbl.push_back('{1, 3, 8'h00});
      tbl.push_back('{1, 12, 8'h00}); tbl.push_back('{1, 15, 8'h00});
      tbl.push_back('{2, 5, 8'h00});  tbl.push_back('{2, 6, 8'hFF});
      tbl.push_back('{2, 9, 8'hFF});  tbl.push_back('{2, 10, 8'hFF});
      tbl.push_back('{2, 1, 8'h00});  tbl.push_back('{2, 4, 8'h00});

      reset = 1'b1;
      gray_ready = 1'b0;
      load_img(0);
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;

      // Table frames; the first holds gray_ready high to show it is ignored after start.
      for (int img = 0; img < 3; img++) begin
         load_img(img);
         do_reset();
         run_frame(img == 0);
         check_table(img);
      end

      // Reset during READ cycle 7 aborts immediately and needs a fresh start strobe.
      load_img(1);
      do_reset();
      @(negedge clk) gray_ready = 1'b1;
      @(negedge clk) gray_ready = 1'b0;
      repeat (7) @(negedge clk);
      check("midframe_addr", gray_addr, 7);
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("abort");
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_idle_req", gray_req, 0);
      check("abort_idle_valid", lbp_valid, 0);
      run_frame(1'b0);
      check_table(1);

      // Random image against the behavioural model.
      load_img(3);
      do_reset();
      run_frame(1'b0);
      for (int k = 0; k < N; k++) check($sformatf("rand_addr%0d", k), got[k], model(k));

      do_reset();
      check("final_reset_finish", finish, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
